// File: rtl/bnn_pkg.sv
// Shared constants and FSM state encoding for the bnn_fc job scheduler.
package bnn_pkg;
  localparam int IN_W    = 400;
  localparam int N_CLASS = 10;
  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 64;

  localparam logic [3:0] CLASS_NONE = 4'hF;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT     = 3'd1,
    HOLD     = 3'd2,
    HOLD_ERR = 3'd3,
    DRAIN    = 3'd4
  } state_t;
endpackage

// File: rtl/bnn_job_fifo.sv
// Job queue: DEPTH entries of {tag, vector}; head is read straight from the storage registers.
module bnn_job_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 404
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [W-1:0]           i_data,
  input  logic                   i_pop,
  output logic [W-1:0]           o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  // Full blocks a push even when a pop happens in the same cycle.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/bnn_fc_sched.sv
// Queues tagged feature vectors, issues them one at a time to bnn_fc and
// returns tagged class results; a watchdog converts a hung job into an error result.
module bnn_fc_sched #(
  parameter int IN_W    = bnn_pkg::IN_W,
  parameter int N_CLASS = bnn_pkg::N_CLASS,
  parameter int DEPTH   = bnn_pkg::DEPTH,
  parameter int TAG_W   = bnn_pkg::TAG_W,
  parameter int TIMEOUT = bnn_pkg::TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [IN_W-1:0]        s_vector,
  input  logic [TAG_W-1:0]       s_tag,
  output logic                   fc_in_valid,
  output logic [IN_W-1:0]        fc_input_vector,
  input  logic                   fc_ready,
  input  logic                   fc_busy,
  input  logic                   fc_out_valid,
  input  logic [N_CLASS-1:0]     fc_out_vector,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [N_CLASS-1:0]     m_scores,
  output logic [3:0]             m_class,
  output logic [TAG_W-1:0]       m_tag,
  output logic                   m_err,
  output logic [$clog2(DEPTH):0] q_count,
  output logic                   sched_busy
);
  import bnn_pkg::*;

  localparam int TW = $clog2(TIMEOUT) + 1;

  state_t                r_state;
  logic                  r_live;
  logic [TW-1:0]         r_timer;
  logic [TAG_W-1:0]      r_job_tag;
  logic                  r_fc_in_valid;
  logic [IN_W-1:0]       r_fc_vec;
  logic                  r_m_valid;
  logic [N_CLASS-1:0]    r_m_scores;
  logic [3:0]            r_m_class;
  logic [TAG_W-1:0]      r_m_tag;
  logic                  r_m_err;

  logic [IN_W+TAG_W-1:0] w_head;
  logic [IN_W-1:0]       w_head_vec;
  logic [TAG_W-1:0]      w_head_tag;
  logic [$clog2(DEPTH):0] w_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_issue;
  logic [3:0]            w_enc;

  // s_ready stays low through the first cycle after reset release.
  assign s_ready    = r_live && !w_full;
  assign w_push     = s_valid && s_ready;
  assign w_issue    = (r_state == IDLE) && r_live && !w_empty && fc_ready && !fc_busy;
  assign {w_head_tag, w_head_vec} = w_head;

  bnn_job_fifo #(
    .DEPTH (DEPTH),
    .W     (IN_W + TAG_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_data  ({s_tag, s_vector}),
    .i_pop   (w_issue),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Lowest set bit wins: scan from the top so bit 0 overrides last.
  always_comb begin
    w_enc = CLASS_NONE;
    for (int i = N_CLASS - 1; i >= 0; i--) begin
      if (fc_out_vector[i]) w_enc = 4'(i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_live        <= 1'b0;
      r_timer       <= '0;
      r_job_tag     <= '0;
      r_fc_in_valid <= 1'b0;
      r_fc_vec      <= '0;
      r_m_valid     <= 1'b0;
      r_m_scores    <= '0;
      r_m_class     <= CLASS_NONE;
      r_m_tag       <= '0;
      r_m_err       <= 1'b0;
    end else begin
      r_live        <= 1'b1;
      r_fc_in_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          // bnn_fc still busy right after reset means a stale job: drain it first.
          if (!r_live && fc_busy) begin
            r_state <= DRAIN;
          end else if (w_issue) begin
            r_fc_vec      <= w_head_vec;
            r_fc_in_valid <= 1'b1;
            r_job_tag     <= w_head_tag;
            r_timer       <= '0;
            r_state       <= WAIT;
          end
        end
        WAIT: begin
          r_timer <= r_timer + 1'b1;
          if (fc_out_valid) begin
            r_m_scores <= fc_out_vector;
            r_m_class  <= w_enc;
            r_m_tag    <= r_job_tag;
            r_m_err    <= 1'b0;
            r_m_valid  <= 1'b1;
            r_state    <= HOLD;
          end else if (r_timer == TW'(TIMEOUT - 1)) begin
            r_m_scores <= '0;
            r_m_class  <= CLASS_NONE;
            r_m_tag    <= r_job_tag;
            r_m_err    <= 1'b1;
            r_m_valid  <= 1'b1;
            r_state    <= HOLD_ERR;
          end
        end
        HOLD: begin
          if (m_ready) begin
            r_m_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        HOLD_ERR: begin
          if (m_ready) begin
            r_m_valid <= 1'b0;
            r_state   <= DRAIN;
          end
        end
        DRAIN: begin
          if (!fc_busy && fc_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign fc_in_valid     = r_fc_in_valid;
  assign fc_input_vector = r_fc_vec;
  assign m_valid         = r_m_valid;
  assign m_scores        = r_m_scores;
  assign m_class         = r_m_class;
  assign m_tag           = r_m_tag;
  assign m_err           = r_m_err;
  assign q_count         = w_count;
  assign sched_busy      = (r_state != IDLE) || !w_empty;
endmodule
